collision_detector: RTL and testbench

COLLISION_DETECTOR -- requirements
Module: collision_detector

---
 rtl/collision_detector.sv | 111 +++++++++++
 tb/tb_collision_detector.sv | 129 ++++++++++++
 2 files changed

// File: rtl/collision_detector.sv
// Sprite move checker: tests the screen boundary, then scans the 16-pixel
// edge strip in the direction of motion against a 1-cycle-latency obstacle map.
module collision_detector (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  link_x_pos,
  input  logic [7:0]  link_y_pos,
  input  logic [2:0]  link_direction,
  output logic [16:0] map_address,
  input  logic        map_q,
  output logic [1:0]  collision,
  output logic        collision_done
);

  typedef enum logic [2:0] {IDLE, BOUND, SCAN, DRAIN, DONE} state_t;

  localparam logic [2:0] DIR_UP    = 3'b010;
  localparam logic [2:0] DIR_DOWN  = 3'b011;
  localparam logic [2:0] DIR_LEFT  = 3'b100;
  localparam logic [2:0] DIR_RIGHT = 3'b101;

  state_t      state, state_nxt;
  logic [8:0]  x_r;
  logic [7:0]  y_r;
  logic [2:0]  dir_r;
  logic [3:0]  idx;
  logic        probe_vld;
  logic        is_move, hit_bound;
  logic [8:0]  px;
  logic [7:0]  py;

  always_comb begin
    is_move   = 1'b0;
    hit_bound = 1'b0;
    case (dir_r)
      DIR_UP:    begin is_move = 1'b1; hit_bound = (y_r == 8'd0);    end
      DIR_DOWN:  begin is_move = 1'b1; hit_bound = (y_r >= 8'd224);  end
      DIR_LEFT:  begin is_move = 1'b1; hit_bound = (x_r == 9'd0);    end
      DIR_RIGHT: begin is_move = 1'b1; hit_bound = (x_r >= 9'd304);  end
      default:   ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BOUND;
      BOUND:   state_nxt = (is_move && !hit_bound) ? SCAN : DONE;
      SCAN:    if (idx == 4'd15) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Probe coordinates; the boundary test keeps every probe on screen.
  always_comb begin
    px = x_r + {5'd0, idx};
    py = y_r;
    case (dir_r)
      DIR_UP:    begin px = x_r + {5'd0, idx}; py = y_r - 8'd1;         end
      DIR_DOWN:  begin px = x_r + {5'd0, idx}; py = y_r + 8'd16;        end
      DIR_LEFT:  begin px = x_r - 9'd1;        py = y_r + {4'd0, idx};  end
      DIR_RIGHT: begin px = x_r + 9'd16;       py = y_r + {4'd0, idx};  end
      default:   ;
    endcase
  end

  always_comb begin
    collision_done = (state == DONE);
    map_address    = 17'd0;
    if (state == SCAN)
      map_address = {1'b0, py, 8'd0} + {3'd0, py, 6'd0} + {8'd0, px};
  end

  // probe_vld marks the cycle in which map_q answers a SCAN address.
  always_ff @(posedge clock) begin
    if (reset) begin
      x_r       <= '0;
      y_r       <= '0;
      dir_r     <= '0;
      idx       <= '0;
      probe_vld <= 1'b0;
      collision <= 2'b00;
    end else begin
      probe_vld <= (state == SCAN);
      case (state)
        IDLE: if (start) begin
          x_r       <= link_x_pos;
          y_r       <= link_y_pos;
          dir_r     <= link_direction;
          collision <= 2'b00;
        end
        BOUND: begin
          idx <= 4'd0;
          if (is_move && hit_bound) collision <= 2'b11;
        end
        SCAN:    idx <= idx + 4'd1;
        default: ;
      endcase
      if (probe_vld && map_q) collision[0] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_collision_detector.sv
// Directed bench for collision_detector with a one-obstacle registered map model.
module tb_collision_detector;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  link_x_pos = '0;
  logic [7:0]  link_y_pos = '0;
  logic [2:0]  link_direction = '0;
  logic [16:0] map_address;
  logic        map_q = 1'b0;
  logic [1:0]  collision;
  logic        collision_done;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic        obs_en = 1'b0;
  int          obs_x = 0;
  int          obs_y = 0;

  collision_detector dut (
    .clock(clock), .reset(reset), .start(start),
    .link_x_pos(link_x_pos), .link_y_pos(link_y_pos), .link_direction(link_direction),
    .map_address(map_address), .map_q(map_q),
    .collision(collision), .collision_done(collision_done)
  );

  always #5 clock = ~clock;

  // Synchronous-read obstacle map holding at most one blocked pixel.
  always @(posedge clock)
    map_q <= obs_en && (int'(map_address) == obs_y * 320 + obs_x);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic run(input string tag, input logic [8:0] x, input logic [7:0] y,
                     input logic [2:0] d, input logic [1:0] ecol, input int elat,
                     input int ereads, input int efirst, input int elast,
                     input bit mid_start);
    int lat, nreads, first_a, last_a, extra;
    lat = -1; nreads = 0; first_a = -1; last_a = -1; extra = 0;
    @(negedge clock);
    link_x_pos = x; link_y_pos = y; link_direction = d; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      if (map_address != 17'd0) begin
        if (nreads == 0) first_a = int'(map_address);
        last_a = int'(map_address);
        nreads++;
      end
      if (mid_start && e == 5) start = 1'b1;
      @(posedge clock); #1;
      if (mid_start && e == 5) start = 1'b0;
      if (collision_done) begin lat = e; break; end
    end
    chk({tag, " latency"}, lat, elat);
    chk({tag, " collision"}, {30'd0, collision}, {30'd0, ecol});
    chk({tag, " reads"}, nreads, ereads);
    if (ereads > 0) begin
      chk({tag, " first addr"}, first_a, efirst);
      chk({tag, " last addr"}, last_a, elast);
    end
    for (int c = 0; c < 25; c++) begin
      @(posedge clock); #1;
      if (collision_done) extra++;
    end
    chk({tag, " extra done"}, extra, 0);
    chk({tag, " collision hold"}, {30'd0, collision}, {30'd0, ecol});
  endtask

  initial begin
    int extra;
    repeat (3) @(posedge clock);
    #1;
    chk("reset collision", {30'd0, collision}, 0);
    chk("reset done", {31'd0, collision_done}, 0);
    chk("reset addr", {15'd0, map_address}, 0);
    reset = 1'b0;

    run("right clear", 9'd100, 8'd50, 3'b101, 2'b00, 18, 16, 50*320+116, 65*320+116, 1'b1);
    obs_en = 1'b1; obs_x = 107; obs_y = 49;
    run("up hit", 9'd100, 8'd50, 3'b010, 2'b01, 18, 16, 49*320+100, 49*320+115, 1'b0);
    obs_x = 116; obs_y = 65;
    run("right last probe", 9'd100, 8'd50, 3'b101, 2'b01, 18, 16, 50*320+116, 65*320+116, 1'b0);
    obs_x = 4; obs_y = 10;
    run("left first probe", 9'd5, 8'd10, 3'b100, 2'b01, 18, 16, 10*320+4, 25*320+4, 1'b0);
    obs_en = 1'b0;
    run("left edge", 9'd0, 8'd96, 3'b100, 2'b11, 1, 0, 0, 0, 1'b0);
    run("attack", 9'd100, 8'd50, 3'b001, 2'b00, 1, 0, 0, 0, 1'b0);
    run("dir 111", 9'd100, 8'd50, 3'b111, 2'b00, 1, 0, 0, 0, 1'b0);
    run("down edge", 9'd200, 8'd224, 3'b011, 2'b11, 1, 0, 0, 0, 1'b0);
    run("up edge", 9'd60, 8'd0, 3'b010, 2'b11, 1, 0, 0, 0, 1'b0);
    run("right edge", 9'd304, 8'd80, 3'b101, 2'b11, 1, 0, 0, 0, 1'b0);
    obs_en = 1'b1; obs_x = 216; obs_y = 239;
    run("down last row", 9'd200, 8'd223, 3'b011, 2'b00, 18, 16, 239*320+200, 239*320+215, 1'b0);
    obs_en = 1'b0;
    run("no move", 9'd10, 8'd10, 3'b000, 2'b00, 1, 0, 0, 0, 1'b0);
    run("right edge again", 9'd310, 8'd20, 3'b101, 2'b11, 1, 0, 0, 0, 1'b0);

    // Abandon a scan at index 7 with reset; no done pulse may follow.
    @(negedge clock);
    link_x_pos = 9'd100; link_y_pos = 8'd50; link_direction = 3'b101; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    chk("scan addr at i=7", {15'd0, map_address}, 57*320+116);
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    chk("abort collision", {30'd0, collision}, 0);
    chk("abort addr", {15'd0, map_address}, 0);
    extra = 0;
    for (int c = 0; c < 25; c++) begin
      if (collision_done) extra++;
      @(posedge clock); #1;
    end
    chk("abort no done", extra, 0);

    run("after abort", 9'd100, 8'd50, 3'b101, 2'b00, 18, 16, 50*320+116, 65*320+116, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
